// File: rtl/dvp_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dvp_frontend
//  Brief    : Oversampling DVP camera front end with byte-lane select, crop
//             window, per-frame line count and sticky error reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module dvp_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             dvp_pclk,
  input  logic             dvp_vsync,
  input  logic             dvp_href,
  input  logic [7:0]       dvp_data,
  input  logic [1:0]       byte_sel,
  input  logic [CNT_W-1:0] crop_x0,
  input  logic [CNT_W-1:0] crop_y0,
  input  logic [CNT_W-1:0] crop_w,
  input  logic [CNT_W-1:0] crop_h,
  output logic             cam_valid,
  output logic             cam_sof,
  output logic [7:0]       cam_pixel,
  output logic [CNT_W-1:0] line_count,
  output logic             frame_done,
  output logic             frame_err
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VSYNC  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // {pclk, vsync, href, data} travel together so the chains stay aligned
  logic [10:0] r_sync [SYNC_STAGES];
  logic [10:0] w_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= {dvp_pclk, dvp_vsync, dvp_href, dvp_data};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  logic       r_pclk_q, r_vsync_q, r_href_q;
  logic       r_ev_pclk_rise, r_ev_vs_rise, r_ev_vs_fall, r_ev_href_fall;
  logic       r_ev_href, r_ev_vsync;
  logic [7:0] r_ev_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pclk_q       <= 1'b0;
      r_vsync_q      <= 1'b0;
      r_href_q       <= 1'b0;
      r_ev_pclk_rise <= 1'b0;
      r_ev_vs_rise   <= 1'b0;
      r_ev_vs_fall   <= 1'b0;
      r_ev_href_fall <= 1'b0;
      r_ev_href      <= 1'b0;
      r_ev_vsync     <= 1'b0;
      r_ev_data      <= '0;
    end else begin
      r_pclk_q       <= w_s[10];
      r_vsync_q      <= w_s[9];
      r_href_q       <= w_s[8];
      r_ev_pclk_rise <= w_s[10] & ~r_pclk_q;
      r_ev_vs_rise   <= w_s[9] & ~r_vsync_q;
      r_ev_vs_fall   <= ~w_s[9] & r_vsync_q;
      r_ev_href_fall <= ~w_s[8] & r_href_q;
      r_ev_href      <= w_s[8];
      r_ev_vsync     <= w_s[9];
      r_ev_data      <= w_s[7:0];
    end
  end

  state_t r_state, w_state_nxt;
  logic   w_enter_vsync, w_frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (r_ev_vs_rise) w_state_nxt = ST_VSYNC;
        ST_VSYNC:  if (r_ev_vs_fall) w_state_nxt = ST_ACTIVE;
        ST_ACTIVE: if (r_ev_vs_rise) w_state_nxt = ST_VSYNC;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
    w_enter_vsync = (w_state_nxt == ST_VSYNC) && (r_state != ST_VSYNC);
    w_frame_end   = enable && (r_state == ST_ACTIVE) && r_ev_vs_rise;
  end

  logic [1:0]       r_sel;
  logic [CNT_W-1:0] r_x0, r_y0, r_w, r_h;
  logic [CNT_W-1:0] r_x, r_y;
  logic             r_byte_idx, r_line_acc, r_sof_armed;

  logic w_active, w_accept, w_keep, w_x_sat, w_y_sat;
  logic w_in_x, w_in_y, w_emit, w_line_end, w_line_used, w_sat_err, w_sync_err;

  always_comb begin
    w_active = enable && (r_state == ST_ACTIVE);
    w_accept = w_active && r_ev_pclk_rise && r_ev_href && !r_ev_vsync;
    case (r_sel)
      2'b01:   w_keep = ~r_byte_idx;
      2'b10:   w_keep = r_byte_idx;
      default: w_keep = 1'b1;
    endcase
    w_x_sat = (r_x == c_CNT_MAX);
    w_y_sat = (r_y == c_CNT_MAX);
    // One extra bit keeps x0 + w from wrapping back into range
    w_in_x = ({1'b0, r_x} >= {1'b0, r_x0}) &&
             ((r_w == '0) || ({1'b0, r_x} < ({1'b0, r_x0} + {1'b0, r_w})));
    w_in_y = ({1'b0, r_y} >= {1'b0, r_y0}) &&
             ((r_h == '0) || ({1'b0, r_y} < ({1'b0, r_y0} + {1'b0, r_h})));
    w_emit      = w_accept && w_keep && !w_x_sat && w_in_x && w_in_y;
    w_line_end  = w_active && r_ev_href_fall;
    w_line_used = r_line_acc || w_accept;
    w_sat_err   = (w_accept && w_keep && w_x_sat) ||
                  (w_line_end && w_line_used && w_y_sat);
    w_sync_err  = r_ev_href && r_ev_vsync;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= '0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_byte_idx  <= 1'b0;
      r_line_acc  <= 1'b0;
      r_sof_armed <= 1'b0;
    end else if (!enable) begin
      r_sof_armed <= 1'b0;
    end else begin
      if (w_line_end) begin
        r_x        <= '0;
        r_byte_idx <= 1'b0;
        r_line_acc <= 1'b0;
        if (w_line_used && !w_y_sat) r_y <= r_y + c_CNT_ONE;
      end else if (w_accept) begin
        r_byte_idx <= ~r_byte_idx;
        r_line_acc <= 1'b1;
        if (w_keep && !w_x_sat) r_x <= r_x + c_CNT_ONE;
      end
      if (w_emit) r_sof_armed <= 1'b0;
      // Frame start wins over any same-cycle counter update
      if (w_enter_vsync) begin
        r_sel       <= byte_sel;
        r_x0        <= crop_x0;
        r_y0        <= crop_y0;
        r_w         <= crop_w;
        r_h         <= crop_h;
        r_x         <= '0;
        r_y         <= '0;
        r_byte_idx  <= 1'b0;
        r_line_acc  <= 1'b0;
        r_sof_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_valid  <= 1'b0;
      cam_sof    <= 1'b0;
      cam_pixel  <= '0;
      frame_done <= 1'b0;
      line_count <= '0;
      frame_err  <= 1'b0;
    end else begin
      cam_valid  <= 1'b0;
      cam_sof    <= 1'b0;
      frame_done <= 1'b0;
      if (!enable) begin
        frame_err <= 1'b0;
      end else begin
        if (w_sync_err || w_sat_err) frame_err <= 1'b1;
        if (w_frame_end) begin
          frame_done <= 1'b1;
          line_count <= r_y;
        end
        if (w_emit) begin
          cam_valid <= 1'b1;
          cam_sof   <= r_sof_armed;
          cam_pixel <= r_ev_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dvp_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dvp_frontend
//  Brief    : Randomized scoreboard bench for dvp_frontend with a frame-level
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dvp_frontend;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
  localparam int MAXV        = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             dvp_pclk, dvp_vsync, dvp_href;
  logic [7:0]       dvp_data;
  logic [1:0]       byte_sel;
  logic [CNT_W-1:0] crop_x0, crop_y0, crop_w, crop_h;
  logic             cam_valid, cam_sof, frame_done, frame_err;
  logic [7:0]       cam_pixel;
  logic [CNT_W-1:0] line_count;

  dvp_frontend #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .dvp_pclk(dvp_pclk), .dvp_vsync(dvp_vsync), .dvp_href(dvp_href), .dvp_data(dvp_data),
    .byte_sel(byte_sel), .crop_x0(crop_x0), .crop_y0(crop_y0), .crop_w(crop_w), .crop_h(crop_h),
    .cam_valid(cam_valid), .cam_sof(cam_sof), .cam_pixel(cam_pixel),
    .line_count(line_count), .frame_done(frame_done), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [8:0] exp_q[$];   // {sof, pixel}
  int         done_q[$];  // expected line_count per completed frame

  // Reference model: the configuration the block should be using this frame
  bit in_frame = 0;
  bit sof_pend = 0;
  int m_sel, m_x0, m_y0, m_w, m_h, m_lines;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [8:0] mon_e;
  int         mon_d;
  always @(negedge clk) begin
    if (rst_n) begin
      if (cam_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pixel: got %02h sof=%0b, expected none (t=%0t)",
                   cam_pixel, cam_sof, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("pixel", int'(cam_pixel), int'(mon_e[7:0]));
          check("sof", int'(cam_sof), int'(mon_e[8]));
        end
      end else if (cam_sof) begin
        vectors++;
        miscompares++;
        $display("FAIL sof_without_valid: got 1, expected 0 (t=%0t)", $time);
      end
      if (frame_done) begin
        if (done_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame_done: got 1, expected 0 (t=%0t)", $time);
        end else begin
          mon_d = done_q.pop_front();
          check("line_count", int'(line_count), mon_d);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected response of one sensor byte: byte j of line l within the frame
  function automatic void model_byte(input int l, input int j, input logic [7:0] d);
    bit kept;
    int x;
    if (in_frame) begin
      kept = (m_sel == 1) ? (j % 2 == 0) : (m_sel == 2) ? (j % 2 == 1) : 1'b1;
      x    = (m_sel == 1 || m_sel == 2) ? j / 2 : j;
      if (kept && x < MAXV) begin
        if (x >= m_x0 && (m_w == 0 || x < m_x0 + m_w) &&
            l >= m_y0 && (m_h == 0 || l < m_y0 + m_h)) begin
          exp_q.push_back({sof_pend, d});
          sof_pend = 1'b0;
        end
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] d);
    dvp_data = d;
    tick(2);
    dvp_pclk = 1'b1;
    tick(4);
    dvp_pclk = 1'b0;
    tick(2);
  endtask

  task automatic send_line(input int l, input int n, input bit pat);
    logic [7:0] d;
    @(negedge clk);
    dvp_href = 1'b1;
    tick(2);
    for (int j = 0; j < n; j++) begin
      d = pat ? 8'(8'h10 + j) : 8'($urandom);
      model_byte(l, j, d);
      send_byte(d);
    end
    dvp_href = 1'b0;
    tick(6);
    if (n > 0 && m_lines < MAXV) m_lines++;
  endtask

  task automatic vsync_rise(input bit href_err);
    @(negedge clk);
    dvp_vsync = 1'b1;
    if (in_frame) done_q.push_back(m_lines);
    if (enable) begin
      in_frame = 1'b1;
      sof_pend = 1'b1;
      m_sel    = (byte_sel == 2'b11) ? 0 : int'(byte_sel);
      m_x0     = int'(crop_x0);
      m_y0     = int'(crop_y0);
      m_w      = int'(crop_w);
      m_h      = int'(crop_h);
      m_lines  = 0;
    end
    tick(6);
    if (href_err) begin
      dvp_href = 1'b1;
      tick(3);
      dvp_href = 1'b0;
    end
    tick(4);
    dvp_vsync = 1'b0;
    tick(8);
  endtask

  // nb = 0 picks a random length for each line
  task automatic run_frame(input int nl, input int nb, input bit pat,
                           input int chg_line, input int chg_x0, input bit herr);
    vsync_rise(herr);
    for (int l = 0; l < nl; l++) begin
      if (l == chg_line) crop_x0 = CNT_W'(chg_x0);
      send_line(l, (nb == 0) ? 1 + int'($urandom % 9) : nb, pat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         got;
    logic [7:0] d;
    rst_n = 1'b0; enable = 1'b0;
    dvp_pclk = 1'b0; dvp_vsync = 1'b0; dvp_href = 1'b0; dvp_data = '0;
    byte_sel = 2'b00; crop_x0 = '0; crop_y0 = '0; crop_w = '0; crop_h = '0;
    tick(3);
    check("rst_cam_valid", int'(cam_valid), 0);
    check("rst_cam_sof", int'(cam_sof), 0);
    check("rst_cam_pixel", int'(cam_pixel), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_line_count", int'(line_count), 0);
    rst_n = 1'b1;
    tick(2);
    enable = 1'b1;
    tick(2);

    // Full frame, byte lanes, crop window, mid-frame config change
    run_frame(4, 8, 0, -1, 0, 0);
    byte_sel = 2'b01;
    run_frame(4, 8, 1, -1, 0, 0);
    byte_sel = 2'b10;
    run_frame(4, 8, 1, -1, 0, 0);
    byte_sel = 2'b00; crop_x0 = 2; crop_w = 3; crop_y0 = 1; crop_h = 2;
    run_frame(4, 8, 0, -1, 0, 0);
    crop_x0 = 1; crop_w = 0; crop_y0 = 0; crop_h = 0;
    run_frame(4, 8, 0, 2, 5, 0);
    run_frame(3, 8, 0, -1, 0, 0);

    for (int f = 0; f < 6; f++) begin
      byte_sel = 2'($urandom % 4);
      crop_x0  = CNT_W'($urandom % 4);
      crop_y0  = CNT_W'($urandom % 3);
      crop_w   = CNT_W'($urandom % 5);
      crop_h   = CNT_W'($urandom % 4);
      run_frame(1 + int'($urandom % 4), 0, 0, -1, 0, 0);
    end

    // Sticky error from href during vsync
    byte_sel = 2'b00; crop_x0 = '0; crop_y0 = '0; crop_w = '0; crop_h = '0;
    check("err_before", int'(frame_err), 0);
    run_frame(2, 6, 0, -1, 0, 1);
    check("err_set", int'(frame_err), 1);
    run_frame(2, 6, 0, -1, 0, 0);
    check("err_sticky", int'(frame_err), 1);

    // One-cycle disable: clears error, drops to IDLE, no frame_done
    @(negedge clk);
    enable   = 1'b0;
    in_frame = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    tick(2);
    check("err_clear", int'(frame_err), 0);
    send_line(0, 6, 0);

    // Line longer than the x counter range
    run_frame(1, 18, 0, -1, 0, 0);
    tick(4);
    check("sat_err", int'(frame_err), 1);

    // Reset in the middle of a line, right as a pixel is presented
    vsync_rise(0);
    @(negedge clk);
    dvp_href = 1'b1;
    tick(2);
    for (int j = 0; j < 2; j++) begin
      d = 8'($urandom);
      model_byte(0, j, d);
      send_byte(d);
    end
    d = 8'($urandom);
    model_byte(0, 2, d);
    dvp_data = d;
    tick(2);
    dvp_pclk = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge clk);
      #1;
      if (cam_valid) got = 1'b1;
    end
    check("rst_wait_valid", int'(got), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_cam_valid", int'(cam_valid), 0);
    check("midrst_cam_pixel", int'(cam_pixel), 0);
    check("midrst_line_count", int'(line_count), 0);
    check("midrst_frame_err", int'(frame_err), 0);
    exp_q.delete();
    done_q.delete();
    in_frame = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    dvp_pclk = 1'b0;
    tick(2);
    for (int j = 3; j < 8; j++) send_byte(8'($urandom));
    dvp_href = 1'b0;
    tick(6);
    send_line(1, 8, 0);
    run_frame(2, 8, 0, -1, 0, 0);
    vsync_rise(0);
    tick(20);
    check("pixels_drained", exp_q.size(), 0);
    check("frames_drained", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dvp_frontend.md
# dvp_frontend

Sensor-side front end for the dashcam capture path. It takes the raw 8-bit DVP parallel camera bus (pclk, vsync, href, data), oversamples it in the system clock domain, and produces the single-cycle `cam_valid` / `cam_sof` / `cam_pixel` strobes that the camera capture stage consumes. The block also applies byte-lane selection and a rectangular crop window, and reports per-frame line count and error status.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on all DVP inputs; legal values are 2 and 3.
- `CNT_W`, default 12: width of the x/y counters and of the crop configuration.

Ports:
- `clk`, input, 1: system clock. All logic runs on this single clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `enable`, input, 1: block enable. When low, the block is forced to IDLE and `cam_valid`/`cam_sof` are held at 0.
- `dvp_pclk`, input, 1: sensor pixel clock. It is sampled as data and never used as a clock.
- `dvp_vsync`, input, 1: frame sync, active high.
- `dvp_href`, input, 1: line valid, active high.
- `dvp_data`, input, 8: sensor data byte.
- `byte_sel`, input, 2: byte lane to keep. 00 keeps all bytes, 01 keeps even bytes (0, 2, 4…), 10 keeps odd bytes, 11 is treated as 00.
- `crop_x0`, input, CNT_W: first kept column.
- `crop_y0`, input, CNT_W: first kept line.
- `crop_w`, input, CNT_W: window width. 0 means unlimited.
- `crop_h`, input, CNT_W: window height. 0 means unlimited.
- `cam_valid`, output, 1: one-cycle strobe per output pixel.
- `cam_sof`, output, 1: asserted together with `cam_valid` on the first in-window pixel of a frame.
- `cam_pixel`, output, 8: pixel byte. Valid only when `cam_valid` = 1.
- `line_count`, output, CNT_W: number of lines in the last completed frame.
- `frame_done`, output, 1: one-cycle pulse at the end of each frame.
- `frame_err`, output, 1: sticky error flag.

## Operation
- **Input synchronization.** All four DVP inputs pass through identical `SYNC_STAGES` flop chains, so they stay mutually aligned.
- **Pixel-clock edge detect.** A pclk rising edge is the synchronized pclk at 1 while the previous synchronized sample was 0.
  - A byte is accepted on a pclk rising edge with synchronized href = 1 and vsync = 0.
- **State machine** (state register resets to IDLE):
  - IDLE: leaves for VSYNC when `enable` = 1 and a vsync rising edge is seen.
  - VSYNC: latches the shadow config, clears `x`, `y`, `byte_idx` and the error-this-frame bit, and arms SOF. Moves to ACTIVE when vsync falls.
  - ACTIVE: accepts bytes and counts lines. A vsync rising edge ends the frame: pulse `frame_done`, load `line_count` with `y`, then go to VSYNC.
  - `enable` low in any state returns to IDLE on the next clk. No `frame_done` is generated and `line_count` is held.
- **Shadow config.** `byte_sel` and the four crop values are captured on entry to VSYNC. Changing them mid-frame has no effect until the next frame.
- **Byte counting.**
  - `byte_idx` (1 bit) toggles on every accepted byte and clears on href falling edge.
  - A byte is kept when `byte_sel` allows its `byte_idx`.
  - `x` counts kept bytes in the current line and clears on href falling edge.
- **Line counting.** `y` increments on an href falling edge only if the line had at least one accepted byte.
- **Window test**, evaluated at CNT_W+1 bits so that x0+w cannot wrap:
  - Horizontal: `x >= x0`, and if `w != 0`, `x < x0 + w`.
  - Vertical: the same test with `y`, `y0` and `h`.
- **Output.** An in-window kept byte produces `cam_valid` = 1 with `cam_pixel` = that byte. `cam_sof` = 1 on the first such byte while SOF is armed, and SOF is then disarmed.
- **Saturation.** `x` and `y` saturate at all-ones and do not wrap. Bytes at a saturated `x` are dropped, and saturation sets `frame_err`.
- **frame_err.** Set by any of:
  - href = 1 while vsync = 1;
  - a vsync rising edge while href = 1;
  - counter saturation.
  
  It is cleared only by `enable` = 0 or reset.

## Timing
- **Reset values.** `cam_valid`, `cam_sof`, `cam_pixel`, `frame_done`, `frame_err` = 0. `line_count` = 0. State = IDLE.
- **Latency.** From a pin-level pclk rising edge to `cam_valid` is SYNC_STAGES + 2 clk cycles: sync chain, then edge-detect register, then output register.
- **Strobe width.** `cam_valid`, `cam_sof` and `frame_done` are each exactly 1 clk wide and registered.
- **Pixel-clock ratio.** Requires f_clk ≥ 4·f_pclk, with pclk high and low phases each ≥ 2 clk. There is no backpressure, because the downstream stage always accepts.
- **frame_done timing.** Asserted 1 clk after the vsync rising edge is detected. `line_count` updates in that same cycle.
- **Simultaneous events.**
  - href falling edge and a byte accept in the same cycle: the byte is processed first, then `x` clears.
  - vsync rise and href high in the same cycle: the byte is not accepted and `frame_err` is set.
- **Reset mid-frame.** All outputs go to their reset values immediately (asynchronous). After reset release, the block waits in IDLE for a full vsync rising edge, so no partial frame is emitted.

## Test plan
- **Full frame, no crop.** 4 lines × 8 bytes, `byte_sel`=00, crop all 0 → 32 `cam_valid`; `cam_sof` only on byte 0 of line 0; `frame_done` on the next vsync; `line_count`=4.
- **Byte-lane select.** `byte_sel`=01, data 0x10..0x17 per line → 0x10, 0x12, 0x14, 0x16 emitted per line. With `byte_sel`=10 → 0x11, 0x13, 0x15, 0x17.
- **Crop window.** x0=2, w=3, y0=1, h=2 on a 4×8 frame → 6 pixels, from line 1 columns 2–4 and line 2 columns 2–4; `cam_sof` on line 1 column 2; `line_count`=4.
- **Mid-frame config change.** Change `crop_x0` during ACTIVE → the current frame is unaffected and the next frame uses the new value.
- **Error and enable.** href asserted during vsync → `frame_err`=1 and stays 1 across frames. Driving `enable`=0 for 1 clk → `frame_err`=0 and state = IDLE.
- **Reset mid-line.** Assert `rst_n`=0 during a line → `cam_valid`=0 immediately. After release, no output until the next vsync rise plus an href line, and the first output pixel carries `cam_sof`=1.
